// File: rtl/sprite_arb_pkg.sv
// Shared constants and types for the sprite ROM arbiter: requester IDs,
// default sizing and the palette index type returned to the layer logic.
package sprite_arb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 8;
  localparam int unsigned ADDR_W_DEFAULT  = 17;
  localparam int unsigned ROM_LAT_DEFAULT = 1;
  localparam int unsigned STAT_W          = 8;

  typedef logic [2:0] req_id_t;
  typedef logic [4:0] pal_index_t;

  localparam req_id_t REQ_PLAYER       = 3'd0;
  localparam req_id_t REQ_ATTACK       = 3'd1;
  localparam req_id_t REQ_ENEMY_ATTACK = 3'd2;
  localparam req_id_t REQ_ENEMY0       = 3'd3;
  localparam req_id_t REQ_ENEMY1       = 3'd4;
  localparam req_id_t REQ_ENEMY2       = 3'd5;
  localparam req_id_t REQ_ENEMY3       = 3'd6;
  localparam req_id_t REQ_OVERLAY      = 3'd7;

  // Saturating increment used by the per-requester wait counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular priority picker: lowest index at or after ptr
// (wrapping) with req set wins; returns a one-hot grant and its index.
module rr_priority_pick
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W:0] REQ_CNT = NUM_REQ[IDX_W:0];

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;
  logic               found;

  // Rotate so bit 0 is the requester at ptr, find the first set bit, then
  // map the offset back to an absolute index modulo NUM_REQ.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k[IDX_W-1:0]]) begin
        found = 1'b1;
        off   = k[IDX_W-1:0];
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= REQ_CNT) begin
      sum = sum - REQ_CNT;
    end
    idx = sum[IDX_W-1:0];
    gnt = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM among the sprite
// layers. Optional per-requester wait statistics under SPRITE_ARB_STATS_EN.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = $bits(pal_index_t),
  parameter int unsigned ROM_LAT = ROM_LAT_DEFAULT
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_start,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]           rom_addr,
  output logic                        rom_rd,
  input  logic [DATA_W-1:0]           rom_data,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]           max_wait
`endif
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned IPIPE_W = ROM_LAT * IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   rom_id;
  logic               transfer;
  logic [ROM_LAT-1:0] vpipe;
  logic [IPIPE_W-1:0] ipipe;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (pick_idx)
  );

  assign transfer = |gnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (frame_start) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      rom_rd   <= 1'b0;
      rom_id   <= '0;
    end else begin
      rom_rd <= transfer;
      if (transfer) begin
        rom_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        rom_id   <= pick_idx;
      end
    end
  end

  // Valid and ID travel in parallel shift chains so the response lines up
  // with rom_data exactly ROM_LAT cycles after the read strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vpipe <= '0;
      ipipe <= '0;
    end else begin
      vpipe <= ROM_LAT'({vpipe, rom_rd});
      ipipe <= IPIPE_W'({ipipe, rom_id});
    end
  end

  assign rsp_valid = vpipe[ROM_LAT-1];
  assign rsp_id    = ipipe[IPIPE_W-1 -: IDX_W];
  assign rsp_data  = rsp_valid ? rom_data : '0;
  assign busy      = (|req) | rom_rd | (|vpipe);

`ifdef SPRITE_ARB_STATS_EN
  logic [STAT_W-1:0] wait_cnt [NUM_REQ];
  logic [STAT_W-1:0] cur_max;

  always_comb begin
    cur_max = max_wait;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (wait_cnt[k[IDX_W-1:0]] > cur_max) begin
        cur_max = wait_cnt[k[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        wait_cnt[k[IDX_W-1:0]] <= '0;
      end
      max_wait <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (gnt[k[IDX_W-1:0]]) begin
          wait_cnt[k[IDX_W-1:0]] <= '0;
        end else if (req[k[IDX_W-1:0]]) begin
          wait_cnt[k[IDX_W-1:0]] <= sat_inc(wait_cnt[k[IDX_W-1:0]]);
        end
      end
      max_wait <= frame_start ? '0 : cur_max;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_sprite_rom_arbiter;
  localparam int N   = 8;
  localparam int AW  = 17;
  localparam int DW  = 5;
  localparam int LAT = 1;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            frame_start = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic            rom_rd;
  logic [DW-1:0]   rom_data = '0;
  logic            rsp_valid;
  logic [2:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            busy;
`ifdef SPRITE_ARB_STATS_EN
  logic [7:0]      max_wait;
`endif

  sprite_rom_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ROM_LAT (LAT)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .rom_data    (rom_data),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .max_wait    (max_wait)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[4:0] ^ a[9:5] ^ a[14:10] ^ {3'b000, a[16:15]} ^ 5'h13;
  endfunction

  // Synchronous ROM, one cycle from address to data.
  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  typedef struct {
    int due;
    int id;
    int data;
  } rsp_t;

  rsp_t          m_q[$];
  int            m_ptr;
  int            cyc;
  bit            m_rom_rd;
  logic [AW-1:0] m_rom_addr;
  int            m_wait [N];
  int            m_max;
  int            want [N];
  logic [AW-1:0] addrs [N];
  int            id_cnt [N];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_q.delete();
    m_rom_rd = 1'b0;
    m_rom_addr = '0;
    m_max = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req[i] = (want[i] > 0);
      req_addr[i*AW +: AW] = addrs[i];
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model at the
  // rising edge, then let the requesters react just after it.
  task automatic step();
    int g;
    int mx;
    logic [N-1:0] exp_gnt;
    bit exp_valid;
    rsp_t r;
    @(negedge Clk);
    g = Reset_n ? model_pick(req, m_ptr) : -1;
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("rom_rd", 32'(rom_rd), 32'(m_rom_rd));
    check_eq("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    check_eq("busy", 32'(busy), 32'((req != 0) || m_rom_rd || (m_q.size() > 0)));
    exp_valid = (m_q.size() > 0) && (m_q[0].due == cyc);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      r = m_q.pop_front();
      check_eq("rsp_id", 32'(rsp_id), 32'(r.id));
      check_eq("rsp_data", 32'(rsp_data), 32'(r.data));
    end
    if (rsp_valid === 1'b1) id_cnt[rsp_id]++;
`ifdef SPRITE_ARB_STATS_EN
    check_eq("max_wait", 32'(max_wait), 32'(m_max));
`endif
    @(posedge Clk);
    if (Reset_n) begin
      mx = m_max;
      for (int i = 0; i < N; i++) if (m_wait[i] > mx) mx = m_wait[i];
      m_max = frame_start ? 0 : mx;
      for (int i = 0; i < N; i++) begin
        if (exp_gnt[i]) m_wait[i] = 0;
        else if (req[i] && m_wait[i] < 255) m_wait[i]++;
      end
      m_rom_rd = (g >= 0);
      if (g >= 0) begin
        m_rom_addr = addrs[g];
        r.due = cyc + 1 + LAT;
        r.id = g;
        r.data = int'(rom_fn(addrs[g]));
        m_q.push_back(r);
        m_ptr = (g + 1) % N;
        want[g]--;
        addrs[g] = AW'($urandom);
      end
      if (frame_start) m_ptr = 0;
    end
    cyc++;
    #1;
    apply_inputs();
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) want[i] = 0;
    apply_inputs();
    for (int k = 0; k < 8; k++) step();
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      want[i] = 0;
      addrs[i] = '0;
      id_cnt[i] = 0;
    end
    model_reset();
    apply_inputs();
    #2;
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset_rom_rd", 32'(rom_rd), 32'd0);
    check_eq("reset_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    step();
    step();
    Reset_n = 1'b1;

    // Single request from requester 3.
    want[3] = 1;
    addrs[3] = 17'h000A5;
    apply_inputs();
    drain();

    // Two simultaneous requests, then a pair that shows where ptr landed.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    want[0] = 1;
    want[5] = 1;
    apply_inputs();
    step();
    step();
    want[0] = 1;
    want[6] = 1;
    apply_inputs();
    drain();

    // Full contention from ptr 0: each requester served three times.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      id_cnt[i] = 0;
      want[i] = 3;
    end
    apply_inputs();
    for (int k = 0; k < 24; k++) step();
    drain();
    for (int i = 0; i < N; i++) check_eq($sformatf("contention_cnt%0d", i), 32'(id_cnt[i]), 32'd3);

    // frame_start while ptr is 4 and requesters 2 and 6 are pending.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    want[3] = 1;
    apply_inputs();
    step();
    want[2] = 1;
    want[6] = 1;
    frame_start = 1'b1;
    apply_inputs();
    step();
    frame_start = 1'b0;
    step();
    drain();

    // Reset asserted one cycle after a grant, with the read in flight.
    want[1] = 1;
    apply_inputs();
    step();
    Reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) want[i] = 0;
    apply_inputs();
    #1;
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst_gnt", 32'(gnt), 32'd0);
    check_eq("midrst_rom_rd", 32'(rom_rd), 32'd0);
    step();
    step();
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    want[5] = 1;
    want[2] = 1;
    apply_inputs();
    drain();

    // Requester 7 blocked behind 0..6, then frame_start clears the maximum.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < N; i++) want[i] = 1;
    apply_inputs();
    drain();
`ifdef SPRITE_ARB_STATS_EN
    check_eq("stats_max7", 32'(max_wait), 32'd7);
`endif
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
`ifdef SPRITE_ARB_STATS_EN
    check_eq("stats_cleared", 32'(max_wait), 32'd0);
`endif

    // Random traffic honouring the hold-until-grant handshake.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        if (want[i] == 0 && ($urandom % 4) == 0) begin
          want[i] = int'($urandom_range(1, 3));
          addrs[i] = AW'($urandom);
        end
      end
      frame_start = (($urandom % 20) == 0);
      apply_inputs();
      step();
    end
    frame_start = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite ROM among the sprite layers: player, attack, enemy attack, four enemies and the overlay.
- Each requester presents a texel address; the arbiter grants one per cycle round-robin and issues the ROM read.
- It returns the 5-bit palette index tagged with the requester ID. The layer logic latches it and feeds the per-layer index inputs of color_mapper.

Parameters:
- NUM_REQ, 8, number of requesters (0 = player ... 7 = overlay).
- ADDR_W, 17, ROM address width.
- DATA_W, 5, palette index width (matches color_mapper indices).
- ROM_LAT, 1, ROM read latency in cycles from rom_addr valid to rom_data valid (1..4).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of frame; resets rotation pointer.
- req  in  NUM_REQ  per-requester read request, level.
- req_addr  in  NUM_REQ x ADDR_W  per-requester address, stable while req high.
- gnt  out  NUM_REQ  one-hot grant, combinational.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_rd  out  1  registered ROM read strobe.
- rom_data  in  DATA_W  ROM read data.
- rsp_valid  out  1  response strobe.
- rsp_id  out  $clog2(NUM_REQ)  requester owning rsp_data.
- rsp_data  out  DATA_W  returned palette index.
- busy  out  1  any read in flight or any req high.

Behaviour:
- Reset (async assert, sync release): ptr=0, rom_addr=0, rom_rd=0, rsp_valid=0, rsp_id=0, rsp_data=0, in-flight pipeline cleared. No response is ever emitted for a read in flight at reset.
- Arbitration: the lowest index i >= ptr (circular) with req[i]=1 gets gnt[i]=1 in the same cycle.
  - gnt is all-zero when req==0.
  - A transfer occurs when req[i]&gnt[i] at the clock edge.
- Handshake: the requester holds req and req_addr until it sees gnt. After a transfer it may keep req high with a new address the next cycle.
- Pointer: on a transfer to i, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
- frame_start: ptr <= 0 at the edge, overriding the transfer update. A grant made in the same cycle still completes and is still delivered.
- Issue: at a transfer edge, rom_addr <= req_addr[i] and rom_rd <= 1; otherwise rom_rd <= 0 and rom_addr holds.
- Response: a shift pipeline of depth ROM_LAT carries {valid,id}.
  - For a grant in cycle t: rsp_valid=1, rsp_id=i, rsp_data=rom_data in cycle t+1+ROM_LAT.
  - Default latency is 2 cycles.
  - Throughput is one response per cycle, and responses are in grant order.
- Full contention (all req high): each requester is served exactly once per NUM_REQ cycles, with no starvation.
- busy = |req | rom_rd | any pipeline valid.

Optional Feature:
- Macro: SPRITE_ARB_STATS_EN.
- Defined: adds output max_wait[7:0] and an internal 8-bit wait counter per requester.
  - A requester's counter increments each cycle req=1 and gnt=0, saturates at 255, and clears on transfer.
  - max_wait is the registered maximum counter value since the last frame_start (cleared to 0 by frame_start and reset).
- Undefined: no counters and no max_wait port. Behaviour is otherwise identical.

Decomposition:
- Package sprite_arb_pkg: NUM_REQ_DEFAULT, requester ID constants (REQ_PLAYER=0, REQ_ATTACK=1, REQ_ENEMY_ATTACK=2, REQ_ENEMY0..3=3..6, REQ_OVERLAY=7), typedef req_id_t, typedef pal_index_t (5-bit).
- One sub-module, rr_priority_pick: combinational circular priority picker. Inputs req and ptr; outputs one-hot gnt and encoded index.

Test Plan:
- Single request: req[3]=1, addr=0x00A5 at t0 -> gnt[3]=1 at t0; rom_addr=0x00A5, rom_rd=1 at t1; rsp_valid=1, rsp_id=3, rsp_data=ROM[0x00A5] at t2.
- Two simultaneous requests: req[0]=req[5]=1 with ptr=0 -> grants to 0 then 5 on consecutive cycles; ptr ends at 6; rsp_id sequence 0,5.
- All 8 held high for 24 cycles -> grant order 0..7 repeating; each ID appears exactly 3 times in rsp_id.
- frame_start with ptr=4 while req[2] and req[6] are high -> next grant goes to 2, not 6; an in-flight response from the prior cycle is still delivered.
- Reset_n pulsed low mid-flight one cycle after a grant -> rsp_valid stays 0, gnt all-zero, ptr=0; no stale response after release.
- With SPRITE_ARB_STATS_EN, req[7] blocked by 0..6 held high for 7 cycles -> max_wait=7; frame_start -> max_wait=0.
